// File: rtl/clock_mode_ctrl_if.sv
// Button/control bundle between the debouncers, clock_mode_ctrl and the
// seconds generator / minute-hour counter chain.
interface clock_mode_ctrl_if #(
    parameter int P_COUNT_BIT = 30
);
    logic                   i_btn_run;
    logic                   i_btn_mode;
    logic                   i_btn_up;
    logic                   i_btn_clr;
    logic                   i_btn_fast;
    logic                   i_sec_tic;
    logic                   o_en;
    logic                   o_reset_s;
    logic                   o_reset_all;
    logic [P_COUNT_BIT-1:0] o_freq;
    logic                   o_min_inc;
    logic                   o_hour_inc;
    logic [1:0]             o_mode;
    logic                   o_blink;

    modport master (
        output i_btn_run, i_btn_mode, i_btn_up, i_btn_clr, i_btn_fast, i_sec_tic,
        input  o_en, o_reset_s, o_reset_all, o_freq, o_min_inc, o_hour_inc,
               o_mode, o_blink
    );

    modport slave (
        input  i_btn_run, i_btn_mode, i_btn_up, i_btn_clr, i_btn_fast, i_sec_tic,
        output o_en, o_reset_s, o_reset_all, o_freq, o_min_inc, o_hour_inc,
               o_mode, o_blink
    );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Mode/sequencing controller for the digital clock: button decode, minute
// carry generation from the sec==59 flag, and set-mode display blink.
//
// state    | meaning
// STOP     | seconds generator held (o_en=0)
// RUN      | seconds generator counting, minute carry active
// SET_MIN  | up button increments minutes, display blinks
// SET_HOUR | up button increments hours, display blinks
module clock_mode_ctrl #(
    parameter int P_COUNT_BIT = 30,
    parameter int P_FREQ_NORM = 100_000_000,
    parameter int P_FREQ_FAST = 1_000_000,
    parameter int P_BLINK_DIV = 25_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    clock_mode_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_STOP     = 2'b00,
        ST_RUN      = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_SET_HOUR = 2'b11
    } state_t;

    localparam int            BW         = (P_BLINK_DIV > 1) ? $clog2(P_BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(P_BLINK_DIV - 1);

    state_t        state_q, state_d;
    logic          fast_q, fast_d;
    logic          reset_all_q, reset_all_d;
    logic          reset_s_q, reset_s_d;
    logic          min_inc_q, min_inc_d;
    logic          hour_inc_q, hour_inc_d;
    logic          blink_q, blink_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          tic_dly_q, tic_dly_d;
    logic          run_prev_q, run_prev_d;
    logic          clr_prev_q, clr_prev_d;

    logic sel_clr, sel_mode, sel_run, sel_fast, sel_up;
    logic carry;

    // Only the highest-priority pulse of a cycle is acted on.
    assign sel_clr  = bus.i_btn_clr;
    assign sel_mode = bus.i_btn_mode & ~bus.i_btn_clr;
    assign sel_run  = bus.i_btn_run  & ~bus.i_btn_clr & ~bus.i_btn_mode;
    assign sel_fast = bus.i_btn_fast & ~bus.i_btn_clr & ~bus.i_btn_mode & ~bus.i_btn_run;
    assign sel_up   = bus.i_btn_up   & ~bus.i_btn_clr & ~bus.i_btn_mode & ~bus.i_btn_run
                      & ~bus.i_btn_fast;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_STOP;
            fast_q      <= 1'b0;
            reset_all_q <= 1'b0;
            reset_s_q   <= 1'b0;
            min_inc_q   <= 1'b0;
            hour_inc_q  <= 1'b0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
            tic_dly_q   <= 1'b0;
            run_prev_q  <= 1'b0;
            clr_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fast_q      <= fast_d;
            reset_all_q <= reset_all_d;
            reset_s_q   <= reset_s_d;
            min_inc_q   <= min_inc_d;
            hour_inc_q  <= hour_inc_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            tic_dly_q   <= tic_dly_d;
            run_prev_q  <= run_prev_d;
            clr_prev_q  <= clr_prev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sel_mode) begin
            case (state_q)
                ST_SET_MIN:  state_d = ST_SET_HOUR;
                ST_SET_HOUR: state_d = ST_RUN;
                default:     state_d = ST_SET_MIN;
            endcase
        end else if (sel_run) begin
            if (state_q == ST_STOP)     state_d = ST_RUN;
            else if (state_q == ST_RUN) state_d = ST_STOP;
        end
    end

    // A carry is only real if sec reached 59 and wrapped while running
    // undisturbed; STOP/SET and clears also drop sec from 59 to 0.
    assign carry = tic_dly_q & ~bus.i_sec_tic & (state_q == ST_RUN) & run_prev_q & ~clr_prev_q;

    always_comb begin
        reset_all_d = sel_clr;
        reset_s_d   = sel_fast;
        fast_d      = fast_q ^ sel_fast;
        min_inc_d   = carry | (sel_up & (state_q == ST_SET_MIN));
        hour_inc_d  = sel_up & (state_q == ST_SET_HOUR);
        tic_dly_d   = bus.i_sec_tic;
        run_prev_d  = (state_q == ST_RUN);
        clr_prev_d  = reset_all_q | reset_s_q;
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (state_d[1]) begin
            if (state_d != state_q) begin
                blink_d = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                blink_d     = blink_q;
            end
        end
    end

    assign bus.o_en        = (state_q == ST_RUN);
    assign bus.o_mode      = state_q;
    assign bus.o_freq      = fast_q ? P_COUNT_BIT'(P_FREQ_FAST) : P_COUNT_BIT'(P_FREQ_NORM);
    assign bus.o_reset_s   = reset_s_q;
    assign bus.o_reset_all = reset_all_q;
    assign bus.o_min_inc   = min_inc_q;
    assign bus.o_hour_inc  = hour_inc_q;
    assign bus.o_blink     = blink_q;
endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
Mode and sequencing controller for the digital clock's seconds generator and its minute/hour counters.
- Turns debounced single-cycle button pulses into the seconds generator's controls: run enable, seconds clear, full clear and count divisor.
- Turns the seconds generator's sec==59 flag into a clean one-per-minute carry pulse.
- Sits between the button debouncers and the sec/min/hour counter chain, and drives the display blink.

Parameters:
P_COUNT_BIT, 30, width of the divisor output (matches seconds generator counter width)
P_FREQ_NORM, 100_000_000, clk cycles per second in normal mode
P_FREQ_FAST, 1_000_000, clk cycles per second in fast (test) mode
P_BLINK_DIV, 25_000_000, clk cycles per half-period of the set-mode blink

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
i_btn_run  input  1  1-cycle pulse; toggles RUN/STOP
i_btn_mode  input  1  1-cycle pulse; advances through the set modes
i_btn_up  input  1  1-cycle pulse; increments the field being set
i_btn_clr  input  1  1-cycle pulse; clears the whole clock
i_btn_fast  input  1  1-cycle pulse; toggles normal/fast rate
i_sec_tic  input  1  level from seconds generator, high while sec==59
o_en  output  1  seconds generator enable
o_reset_s  output  1  1-cycle seconds clear
o_reset_all  output  1  1-cycle full clear (sec/min/hour)
o_freq  output  P_COUNT_BIT  divisor to seconds generator
o_min_inc  output  1  1-cycle minute increment
o_hour_inc  output  1  1-cycle hour increment
o_mode  output  2  00 STOP, 01 RUN, 10 SET_MIN, 11 SET_HOUR
o_blink  output  1  display blink for the field being set

Behaviour:
Reset:
- Reset is async on reset_n low, with synchronous deassert use.
- On reset: state=STOP, fast=0, blink counter=0, tic delay reg=0.
- All pulse outputs=0, o_en=0, o_blink=0, o_freq=P_FREQ_NORM.

Button priority when several pulses arrive in the same cycle: clr > mode > run > fast > up; lower-priority pulses in that cycle are dropped.

State transitions (registered, take effect on the edge after the pulse):
- STOP --run--> RUN; RUN --run--> STOP.
- STOP/RUN --mode--> SET_MIN --mode--> SET_HOUR --mode--> RUN.
- run in SET_* is ignored.
- clr in any state: o_reset_all pulses 1 cycle; state unchanged.

Decoded outputs:
- o_en = (state==RUN), decoded directly from the state register.
- Leaving RUN drops o_en, so the seconds generator zeroes sec; setting time therefore always restarts seconds at 0.

Set-mode increments:
- up in SET_MIN: o_min_inc pulses 1 cycle.
- up in SET_HOUR: o_hour_inc pulses 1 cycle.
- up in RUN/STOP is ignored.

Fast toggle:
- fast toggles the fast flag; o_freq = fast ? P_FREQ_FAST : P_FREQ_NORM, registered.
- On every toggle, o_reset_s pulses in the same cycle o_freq changes. This prevents the seconds generator's counter from sitting above the new divisor.

Minute carry:
- Track tic_d = i_sec_tic delayed one cycle.
- o_min_inc pulses 1 cycle after a falling edge (tic_d=1, i_sec_tic=0), only if all of the following hold:
  - state was RUN in both the edge cycle and the previous cycle;
  - o_reset_all and o_reset_s were both 0 in the previous cycle.
- This suppresses spurious carries caused by STOP/SET zeroing or by clears.
- A carry and a set-mode increment can never coincide, because carry requires RUN.

Blink:
- In SET_* states, the blink counter counts 0..P_BLINK_DIV-1 and o_blink toggles on each wrap.
- On entering any SET_* state, counter=0 and o_blink=1.
- In RUN/STOP, the counter is held at 0 and o_blink=0.

Pulse timing:
- All pulses are exactly 1 cycle, registered.
- Latency is 1 cycle from the input pulse.

Test Plan:
Bench parameters: P_FREQ_NORM=10, P_FREQ_FAST=2, P_BLINK_DIV=4; seconds generator instantiated.
- Reset then run pulse -> o_mode=01, o_en=1 next cycle; o_freq=10; after 600 cycles exactly one o_min_inc pulse, 1 cycle after sec goes 59->0.
- RUN with sec=59, then run pulse -> o_en=0, sec forced to 0, no o_min_inc.
- Same setup with clr pulse in RUN -> o_reset_all high 1 cycle, no o_min_inc.
- mode x3 from STOP -> o_mode 10, 11, 01. Three up pulses in SET_MIN -> three o_min_inc pulses; two in SET_HOUR -> two o_hour_inc pulses. o_blink=1 on entry, then toggles every 4 cycles; o_blink=0 back in RUN.
- fast pulse while RUN with counter at 7 -> o_freq=2 and o_reset_s pulse in the same cycle; sec then increments every 2 cycles.
- clr+mode+up in the same cycle -> only o_reset_all; state unchanged.
- reset_n low mid-SET_HOUR with blink=0 -> immediately o_mode=00, o_en=0, o_blink=0, o_freq=10, all pulses 0.
